// File: rtl/div.sv
// 32-bit restoring divider (signed/unsigned) with registered {remainder, quotient} result.
// Optional abort port annul_i is enabled by defining DIV_ANNUL_EN.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
`ifdef DIV_ANNUL_EN
  input  logic        annul_i,
`endif
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {IDLE, DZERO, BUSY, DONE} state_t;

  state_t      state_r;
  state_t      state_s;
  logic [5:0]  cnt_r;
  logic [63:0] work_r;
  logic [31:0] divisor_r;
  logic        neg_q_r;
  logic        neg_rem_r;
  logic        annul_s;
  logic [32:0] part_s;
  logic [32:0] diff_s;
  logic [63:0] step_s;
  logic [63:0] fix_s;
  logic        accept_s;

`ifdef DIV_ANNUL_EN
  assign annul_s = annul_i;
`else
  assign annul_s = 1'b0;
`endif

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
    cond_neg = en ? (~v + 32'd1) : v;
  endfunction

  assign accept_s = start_i && !annul_s;

  // One restoring step: bit 32 of diff_s is the borrow, i.e. partial < divisor.
  assign part_s = work_r[63:31];
  assign diff_s = part_s - {1'b0, divisor_r};
  assign step_s = diff_s[32] ? {work_r[62:0], 1'b0}
                             : {diff_s[31:0], work_r[30:0], 1'b1};
  assign fix_s  = {cond_neg(work_r[63:32], neg_rem_r), cond_neg(work_r[31:0], neg_q_r)};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (opdata2_i == 32'd0) ? DZERO : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      DZERO: begin
        if (annul_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      BUSY: begin
        if (annul_s) begin
          state_s = IDLE;
        end else if (cnt_r == 6'd32) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (ready_o && !start_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture as magnitudes, shift-subtract iterations, final sign fix
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= 6'd0;
      work_r    <= 64'd0;
      divisor_r <= 32'd0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            work_r    <= {32'd0, cond_neg(opdata1_i, signed_div_i && opdata1_i[31])};
            divisor_r <= cond_neg(opdata2_i, signed_div_i && opdata2_i[31]);
            neg_q_r   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_r <= signed_div_i && opdata1_i[31];
            cnt_r     <= 6'd0;
          end
        end
        DZERO: begin
          work_r <= 64'd0;
          cnt_r  <= 6'd0;
        end
        BUSY: begin
          if (annul_s) begin
            cnt_r <= 6'd0;
          end else if (cnt_r == 6'd32) begin
            work_r <= fix_s;
          end else begin
            work_r <= step_s;
            cnt_r  <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          cnt_r <= 6'd0;
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

  // Output registers: raised on the first DONE edge, cleared when the request drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_o  <= 1'b0;
      result_o <= 64'd0;
    end else begin
      case (state_r)
        DONE: begin
          if (!ready_o) begin
            ready_o  <= 1'b1;
            result_o <= work_r;
          end else if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: timeline reference model compared every cycle,
// directed literal cases, randomized operands, async reset and (optionally) annul.
module tb_div;

  logic        clk;
  logic        rst;
  logic        sdiv;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [63:0] m_res;
  logic        m_ready;
  logic        m_busy;
  logic        m_done;
  logic [63:0] m_pend;
  int          m_edges;
  int          m_lat;

  div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(sdiv),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
`ifdef DIV_ANNUL_EN
    .annul_i     (annul),
`endif
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepts a request when idle, reports after the fixed latency
  initial begin
    m_res = 64'd0; m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_pend = 64'd0; m_edges = 0; m_lat = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_res = 64'd0; m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_edges = 0;
      end else if (m_busy) begin
`ifdef DIV_ANNUL_EN
        if (annul) begin
          m_busy = 1'b0;
        end else
`endif
        begin
          m_edges++;
          if (m_edges == m_lat) begin
            m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1; m_res = m_pend;
          end
        end
      end else if (m_done) begin
        if (!start) begin
          m_done = 1'b0; m_ready = 1'b0; m_res = 64'd0;
        end
      end else if (start && !annul) begin
        m_busy  = 1'b1;
        m_edges = 0;
        m_pend  = ref_div(op1, op2, sdiv);
        m_lat   = (op2 == 32'd0) ? 2 : 34;
      end
    end
  end

  // Cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        total++;
        if (ready_o !== m_ready || result_o !== m_res) begin
          bad++;
          $display("FAIL cycle: got ready=%0b result=%h expected ready=%0b result=%h (t=%0t)",
                   ready_o, result_o, m_ready, m_res, $time);
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input int lat,
                        input int hold, input bit scramble);
    int k;
    bit seen;
    @(posedge clk); #1;
    op1 = a; op2 = b; sdiv = s; start = 1'b1;
    @(posedge clk); #1;
    k = 0; seen = 1'b0;
    while (!seen && k < 60) begin
      if (ready_o) begin
        seen = 1'b1;
      end else begin
        if (scramble) begin
          op1 = $urandom; op2 = $urandom; sdiv = 1'($urandom);
          if (lat == 34 && k == 5) start = 1'b0;
          if (k == 10) start = 1'b1;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    chk({name, " latency"}, 64'(k), 64'(lat));
    chk({name, " result"}, result_o, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, " hold"}, {63'd0, ready_o}, 64'd1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, " drop"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          k;
    rst = 1'b0; start = 1'b0; annul = 1'b0; sdiv = 1'b0; op1 = 32'd0; op2 = 32'd0;
    #12;
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    #11 rst = 1'b1;

    run_op("u100/7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 2, 1'b0);
    run_op("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, 0, 1'b0);
    run_op("u-7/2", 32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 34, 1, 1'b0);
    run_op("div0", 32'h12345678, 32'd0, 1'b1, 64'd0, 2, 1, 1'b0);
    run_op("smin/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34, 0, 1'b1);
    run_op("umin/-1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 34, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      run_op("rand", a, b, s, ref_div(a, b, s), (b == 32'd0) ? 2 : 34,
             $urandom_range(0, 3), 1'b1);
    end

    // async reset mid-BUSY, then while results are shown
    @(posedge clk); #1;
    op1 = 32'd100; op2 = 32'd7; sdiv = 1'b0; start = 1'b1;
    repeat (21) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst busy ready", {63'd0, ready_o}, 64'd0);
    chk("rst busy result", result_o, 64'd0);
    start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    k = 0;
    while (!ready_o && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("pre-rst done", result_o, 64'h00000002_0000000E);
    #2 rst = 1'b0;
    #1;
    chk("rst done ready", {63'd0, ready_o}, 64'd0);
    chk("rst done result", result_o, 64'd0);
    start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    run_op("post-rst", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 0, 1'b0);

`ifdef DIV_ANNUL_EN
    @(posedge clk); #1;
    op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1 annul = 1'b1; start = 1'b0;
    @(posedge clk); #1 annul = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("annul busy", {63'd0, ready_o}, 64'd0);
    end
    run_op("annul 9/3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 34, 0, 1'b0);
    @(posedge clk); #1;
    op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(posedge clk); #1 annul = 1'b1; start = 1'b0;
    @(posedge clk); #1 annul = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("annul dzero", {63'd0, ready_o}, 64'd0);
    end
    @(posedge clk); #1 annul = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1 annul = 1'b0; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("annul idle", {63'd0, ready_o}, 64'd0);
    end
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
